// File: rtl/sm_regport_arb_if.sv
// sm_regport_arb_if: display/dump request and register-file debug read signals.
interface sm_regport_arb_if;
  logic [4:0]  dispAddr;
  logic        scanMode;
  logic [31:0] dispData;
  logic        dumpReq;
  logic [4:0]  dumpAddr;
  logic        dumpAck;
  logic [31:0] dumpData;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        busy;
  modport slave (input dispAddr, scanMode, dumpReq, dumpAddr, regData,
                 output dispData, dumpAck, dumpData, regAddr, busy);
  modport master (output dispAddr, scanMode, dumpReq, dumpAddr, regData,
                  input dispData, dumpAck, dumpData, regAddr, busy);
endinterface

// File: rtl/sm_regport_arb.sv
// sm_regport_arb: arbitrates display refresh and dump reads onto one register-file debug port.
// Optional auto-scan of the display address: define SM_REGPORT_ARB_AUTOSCAN_EN.
module sm_regport_arb #(
  parameter int WAIT_CYCLES    = 1,
  parameter int REFRESH_CYCLES = 1024,
  parameter int DWELL_CYCLES   = 25000000
) (
  input logic clk,
  input logic rst_n,
  sm_regport_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAP} state_t;
  localparam logic [3:0]  WAIT_RELOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] REF_RELOAD  = 16'(REFRESH_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0]  wait_cnt;
  logic [15:0] ref_cnt;
  logic        pend, last_dump, grant_dump, dump_ok, take_dump;
  logic [4:0]  disp_src;
`ifdef SM_REGPORT_ARB_AUTOSCAN_EN
  localparam logic [31:0] DWELL_RELOAD = 32'(DWELL_CYCLES - 1);
  logic [31:0] dwell_cnt;
  logic [4:0]  scan_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dwell_cnt <= DWELL_RELOAD;
      scan_idx  <= 5'd0;
    end else if (bus.scanMode) begin
      dwell_cnt <= (dwell_cnt == 32'd0) ? DWELL_RELOAD : dwell_cnt - 32'd1;
      scan_idx  <= (dwell_cnt == 32'd0) ? scan_idx + 5'd1 : scan_idx;
    end
  assign disp_src = bus.scanMode ? scan_idx : bus.dispAddr;
`else
  logic unused_scan;
  assign unused_scan = bus.scanMode;
  assign disp_src = bus.dispAddr;
`endif
  // a request still high in its own ack cycle belongs to the finished transaction
  assign dump_ok   = bus.dumpReq & ~bus.dumpAck;
  assign take_dump = dump_ok & (~pend | ~last_dump);
  assign bus.busy  = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (pend | dump_ok) ? ADDR : IDLE;
      ADDR:    state_nx = WAIT;
      WAIT:    state_nx = (wait_cnt == 4'd0) ? CAP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      ref_cnt      <= REF_RELOAD;
      pend         <= 1'b1;
      last_dump    <= 1'b1;
      grant_dump   <= 1'b0;
      bus.regAddr  <= 5'd0;
      bus.dispData <= 32'd0;
      bus.dumpData <= 32'd0;
      bus.dumpAck  <= 1'b0;
    end else begin
      state       <= state_nx;
      ref_cnt     <= (ref_cnt == 16'd0) ? REF_RELOAD : ref_cnt - 16'd1;
      // a new refresh tick wins over the clear from a finishing display read
      pend        <= (ref_cnt == 16'd0) | (pend & ~(state == CAP & ~grant_dump));
      bus.dumpAck <= (state == CAP) & grant_dump;
      if (state == IDLE & state_nx == ADDR) begin
        grant_dump <= take_dump;
        last_dump  <= take_dump;
      end
      if (state == ADDR) begin
        bus.regAddr <= grant_dump ? bus.dumpAddr : disp_src;
        wait_cnt    <= WAIT_RELOAD;
      end
      if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (state == CAP & grant_dump) bus.dumpData <= bus.regData;
      if (state == CAP & ~grant_dump) bus.dispData <= bus.regData;
    end
endmodule
